uart_rx_byte: RTL and testbench

//  8N1 UART receiver feeding the Reed-Solomon input framing FSM. Oversamples serial line Rx_D at 16x,

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_baud_tick.sv | 29 ++
 rtl/uart_rx_byte.sv | 122 ++++++++++++
 tb/tb_uart_rx_byte.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared encodings and constants for the 8N1 UART receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StStart = 3'd1,
    StData  = 3'd2,
    StStop  = 3'd3,
    StBreak = 3'd4
  } rx_state_e;

  localparam int unsigned OVERSAMPLE  = 16;
  localparam int unsigned SampleW     = $clog2(OVERSAMPLE);
  localparam int unsigned DATA_BITS   = 8;
  localparam logic [SampleW-1:0] MID_SAMPLE  = SampleW'(OVERSAMPLE / 2 - 1);
  localparam logic [SampleW-1:0] LAST_SAMPLE = SampleW'(OVERSAMPLE - 1);

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running oversample tick: one-cycle pulse every BAUD_DIV clocks.
module uart_baud_tick #(
  parameter int unsigned BAUD_DIV = 27
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int unsigned CntW = $clog2(BAUD_DIV);
  localparam logic [CntW-1:0] CntMax = CntW'(BAUD_DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == CntMax);

  always_comb begin
    cnt_d = tick ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver, 16x oversampled, centre sampling, sticky frame error with
// line-break lockout.
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int unsigned BAUD_DIV = 27
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 Rx_D,
  output logic [DATA_BITS-1:0] Rx_DATA,
  output logic                 Rx_VALID,
  output logic                 Rx_FERROR,
  output logic                 Rx_BUSY
);

  logic tick;

  uart_baud_tick #(
    .BAUD_DIV(BAUD_DIV)
  ) u_baud_tick (
    .clk  (clk),
    .reset(reset),
    .tick (tick)
  );

  logic                 rx_meta_q, rx_s_q;
  rx_state_e            state_q, state_d;
  logic [SampleW-1:0]   sample_cnt_q, sample_cnt_d;
  logic [2:0]           bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferror_q, ferror_d;
  logic                 busy_q, busy_d;

  always_comb begin
    state_d      = state_q;
    sample_cnt_d = tick ? sample_cnt_q + 1'b1 : sample_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    data_d       = data_q;
    valid_d      = 1'b0;
    ferror_d     = ferror_q;

    case (state_q)
      StIdle: begin
        if (!rx_s_q) state_d = StStart;
      end
      StStart: begin
        if (tick && sample_cnt_q == MID_SAMPLE) begin
          if (rx_s_q) begin
            state_d = StIdle;
          end else begin
            state_d   = StData;
            bit_cnt_d = '0;
          end
        end
      end
      StData: begin
        if (tick && sample_cnt_q == LAST_SAMPLE) begin
          shift_d[bit_cnt_q] = rx_s_q;
          bit_cnt_d          = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = StStop;
        end
      end
      StStop: begin
        if (tick && sample_cnt_q == LAST_SAMPLE) begin
          if (rx_s_q) begin
            data_d   = shift_q;
            valid_d  = 1'b1;
            ferror_d = 1'b0;
            state_d  = StIdle;
          end else begin
            ferror_d = 1'b1;
            state_d  = StBreak;
          end
        end
      end
      // A held-low line must return high before a new start bit can arm.
      StBreak: begin
        if (rx_s_q) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (state_d != state_q) sample_cnt_d = '0;
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rx_meta_q    <= 1'b1;
      rx_s_q       <= 1'b1;
      state_q      <= StIdle;
      sample_cnt_q <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      ferror_q     <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      rx_meta_q    <= Rx_D;
      rx_s_q       <= rx_meta_q;
      state_q      <= state_d;
      sample_cnt_q <= sample_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      ferror_q     <= ferror_d;
      busy_q       <= busy_d;
    end
  end

  assign Rx_DATA   = data_q;
  assign Rx_VALID  = valid_q;
  assign Rx_FERROR = ferror_q;
  assign Rx_BUSY   = busy_q;

endmodule

// File: tb/tb_uart_rx_byte.sv
// Bench for uart_rx_byte: a UART line model drives frames, a scoreboard queue
// holds the bytes a correct receiver must deliver, and a monitor checks each pulse.
`timescale 1ns/1ps
module tb_uart_rx_byte;

  localparam int unsigned BaudDiv = 4;
  localparam int Nominal = 16 * BaudDiv * 100;  // bit period in hundredths of a clk
  localparam int BitClk  = 16 * BaudDiv;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rx_d = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid, rx_ferror, rx_busy;

  int         n_checks = 0;
  int         n_errors = 0;
  int         n_valid = 0;
  int         mark;
  logic [7:0] exp_q[$];
  logic       valid_prev = 1'b0;
  logic       busy_prev = 1'b0;

  always #5 clk = ~clk;

  uart_rx_byte #(
    .BAUD_DIV(BaudDiv)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .Rx_D     (rx_d),
    .Rx_DATA  (rx_data),
    .Rx_VALID (rx_valid),
    .Rx_FERROR(rx_ferror),
    .Rx_BUSY  (rx_busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle_bits(input int n);
    rx_d = 1'b1;
    cycles(n * BitClk);
  endtask

  // Drives start, 8 data bits LSB first, stop; bit edges placed at round(i*per/100).
  task automatic send_frame(input logic [7:0] b, input int per, input logic stop,
                            input logic expect_byte);
    logic [9:0] bits;
    int         t_prev, t_next;
    bits = {stop, b, 1'b0};
    if (expect_byte) exp_q.push_back(b);
    t_prev = 0;
    for (int i = 0; i < 10; i++) begin
      t_next = ((i + 1) * per + 50) / 100;
      rx_d = bits[i];
      cycles(t_next - t_prev);
      t_prev = t_next;
    end
  endtask

  task automatic wait_drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 4 * BitClk) begin
      cycles(1);
      k++;
    end
    check("scoreboard_drained", exp_q.size(), 0);
  endtask

  // Monitor: every pulse must be single, coincide with BUSY falling, and match the queue head.
  initial begin
    forever begin
      @(negedge clk);
      if (rx_valid) begin
        n_valid++;
        check("valid_single_cycle", valid_prev, 1'b0);
        check("busy_before_valid", busy_prev, 1'b1);
        check("busy_low_on_valid", rx_busy, 1'b0);
        check("ferror_clear_on_valid", rx_ferror, 1'b0);
        if (exp_q.size() == 0) begin
          check("valid_was_expected", exp_q.size(), 1);
        end else begin
          check("rx_data", rx_data, exp_q.pop_front());
        end
      end
      valid_prev = rx_valid;
      busy_prev  = rx_busy;
    end
  end

  initial begin
    repeat (90000) @(posedge clk);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values.
    reset = 1'b0;
    cycles(3);
    check("reset_data", rx_data, 8'h00);
    check("reset_valid", rx_valid, 1'b0);
    check("reset_ferror", rx_ferror, 1'b0);
    check("reset_busy", rx_busy, 1'b0);
    reset = 1'b1;
    idle_bits(2);

    // Single nominal frame.
    send_frame(8'hA5, Nominal, 1'b1, 1'b1);
    idle_bits(1);
    wait_drain();
    check("a5_ferror", rx_ferror, 1'b0);

    // Short low glitch must only flash BUSY.
    mark = n_valid;
    rx_d = 1'b0;
    cycles(10);
    check("glitch_busy_high", rx_busy, 1'b1);
    cycles(10);
    rx_d = 1'b1;
    cycles(30);
    check("glitch_busy_low", rx_busy, 1'b0);
    check("glitch_no_valid", n_valid, mark);
    idle_bits(1);
    send_frame(8'h3C, Nominal, 1'b1, 1'b1);
    idle_bits(1);
    wait_drain();

    // Framing error, held-low break, then recovery.
    send_frame(8'h11, Nominal, 1'b1, 1'b1);
    idle_bits(1);
    wait_drain();
    mark = n_valid;
    send_frame(8'h55, Nominal, 1'b0, 1'b0);
    cycles(30 * BitClk);
    check("break_ferror", rx_ferror, 1'b1);
    check("break_data_held", rx_data, 8'h11);
    check("break_busy", rx_busy, 1'b1);
    check("break_no_valid", n_valid, mark);
    idle_bits(2);
    check("break_released", rx_busy, 1'b0);
    send_frame(8'h0F, Nominal, 1'b1, 1'b1);
    idle_bits(1);
    wait_drain();
    check("recover_ferror", rx_ferror, 1'b0);
    check("recover_data", rx_data, 8'h0F);

    // Baud mismatch of +4 % and -4 %.
    send_frame(8'h96, 6656, 1'b1, 1'b1);
    idle_bits(1);
    send_frame(8'h96, 6144, 1'b1, 1'b1);
    idle_bits(1);
    wait_drain();
    check("skew_ferror", rx_ferror, 1'b0);

    // Reset in the middle of data bit 4 of 0x77.
    fork
      send_frame(8'h77, Nominal, 1'b1, 1'b0);
      begin
        cycles(5 * BitClk + BitClk / 2);
        reset = 1'b0;
        cycles(1);
        reset = 1'b1;
        check("midreset_data", rx_data, 8'h00);
        check("midreset_valid", rx_valid, 1'b0);
        check("midreset_ferror", rx_ferror, 1'b0);
        check("midreset_busy", rx_busy, 1'b0);
        // The 0 in data bit 7 now looks like a start bit; the idle-high line
        // that follows makes it a well-framed 0xFF.
        exp_q.push_back(8'hFF);
      end
    join
    idle_bits(6);
    wait_drain();
    send_frame(8'hFF, Nominal, 1'b1, 1'b1);
    idle_bits(1);
    wait_drain();

    // Back-to-back burst of random bytes.
    mark = n_valid;
    for (int i = 0; i < 64; i++) begin
      send_frame(8'($urandom_range(0, 255)), Nominal, 1'b1, 1'b1);
    end
    idle_bits(1);
    wait_drain();
    check("burst_count", n_valid - mark, 64);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
